// File: rtl/csr_eu_bcast_if.sv
// Bundle of the issue-side request and the broadcast result bus of the
// CSR execution unit. The slave modport is the unit's view; the master
// modport is the view of whoever drives operations and acts as consumers.
//
// Handshake rules: a transfer happens on a rising clock edge when valid and
// ready are both high. On the request side, in_ready does not depend on in_valid.
// On the broadcast side, each consumer i has its own valid/ready pair.
// Head data stays stable while any out_valid bit is high. A ready seen
// while its valid is low is ignored.
interface csr_eu_bcast_if #(
    parameter int XLEN     = 32,
    parameter int TAG_W    = 4,
    parameter int NUM_CONS = 4
);
    logic                in_valid;
    logic                in_ready;
    logic [2:0]          in_op;
    logic [TAG_W-1:0]    in_tag;
    logic                in_is_env;
    logic                in_is_mret;
    logic [11:0]         in_csraddr;
    logic [XLEN-1:0]     in_csrdata;
    logic [XLEN-1:0]     in_src;
    logic [4:0]          in_areg;

    logic [NUM_CONS-1:0] out_valid;
    logic [NUM_CONS-1:0] out_ready;
    logic [XLEN-1:0]     out_csrdata;
    logic [XLEN-1:0]     out_result;
    logic                out_wen;
    logic                out_illegal;
    logic [TAG_W-1:0]    out_tag;
    logic [11:0]         out_csraddr;
    logic [4:0]          out_areg;
    logic                out_is_env;
    logic                out_is_mret;

    modport slave (
        input  in_valid, in_op, in_tag, in_is_env, in_is_mret,
               in_csraddr, in_csrdata, in_src, in_areg, out_ready,
        output in_ready, out_valid, out_csrdata, out_result, out_wen,
               out_illegal, out_tag, out_csraddr, out_areg,
               out_is_env, out_is_mret
    );

    modport master (
        output in_valid, in_op, in_tag, in_is_env, in_is_mret,
               in_csraddr, in_csrdata, in_src, in_areg, out_ready,
        input  in_ready, out_valid, out_csrdata, out_result, out_wen,
               out_illegal, out_tag, out_csraddr, out_areg,
               out_is_env, out_is_mret
    );
endinterface

// File: rtl/csr_eu_bcast.sv
// CSR execution unit with a result FIFO whose head entry is broadcast to
// NUM_CONS consumers. The new CSR value and write enable are computed when
// an operation is accepted. An entry retires once every consumer has taken it.
module csr_eu_bcast #(
    parameter int XLEN     = 32,
    parameter int TAG_W    = 4,
    parameter int NUM_CONS = 4,
    parameter int DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst,
    csr_eu_bcast_if.slave      bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0]  csrdata;
        logic [XLEN-1:0]  result;
        logic             wen;
        logic             illegal;
        logic [TAG_W-1:0] tag;
        logic [11:0]      csraddr;
        logic [4:0]       areg;
        logic             is_env;
        logic             is_mret;
    } entry_t;

    entry_t              r_mem [DEPTH];
    logic [PW-1:0]       r_rd_ptr;
    logic [PW-1:0]       r_wr_ptr;
    logic [CW-1:0]       r_count;
    logic [NUM_CONS-1:0] r_done;

    entry_t              w_new;
    entry_t              w_head;
    logic                w_push;
    logic                w_pop;
    logic                w_in_ready;
    logic [NUM_CONS-1:0] w_valid;
    logic [NUM_CONS-1:0] w_fired;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Fullness only: a retire in the same cycle never frees a slot early.
    assign w_in_ready = (r_count < CW'(DEPTH));
    assign w_push     = bus.in_valid & w_in_ready;
    assign w_valid    = (r_count != '0) ? ~r_done : '0;
    assign w_fired    = w_valid & bus.out_ready;
    assign w_pop      = (r_count != '0) && ((r_done | w_fired) == '1);
    assign w_head     = r_mem[r_rd_ptr];

    // Compute the entry to be stored from the presented operation.
    always_comb begin
        w_new         = '0;
        w_new.csrdata = bus.in_csrdata;
        w_new.tag     = bus.in_tag;
        w_new.csraddr = bus.in_csraddr;
        w_new.areg    = bus.in_areg;
        w_new.is_env  = bus.in_is_env;
        w_new.is_mret = bus.in_is_mret;
        w_new.result  = bus.in_csrdata;
        case (bus.in_op)
            3'b000: begin
                w_new.result = bus.in_src;
                w_new.wen    = 1'b1;
            end
            3'b001: begin
                w_new.result = bus.in_csrdata | bus.in_src;
                w_new.wen    = (bus.in_areg != 5'd0);
            end
            3'b010: begin
                w_new.result = bus.in_csrdata & ~bus.in_src;
                w_new.wen    = (bus.in_areg != 5'd0);
            end
            3'b011: begin
                w_new.wen    = 1'b0;
            end
            default: begin
                w_new.illegal = 1'b1;
            end
        endcase
    end

    // Entry storage; cleared on reset so idle outputs read zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= w_new;
        end
    end

    // FIFO pointers, occupancy and the per-consumer taken mask.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_done   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
                r_done   <= '0;
            end else begin
                r_done   <= r_done | w_fired;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = w_valid;
    assign bus.out_csrdata = w_head.csrdata;
    assign bus.out_result  = w_head.result;
    assign bus.out_wen     = w_head.wen;
    assign bus.out_illegal = w_head.illegal;
    assign bus.out_tag     = w_head.tag;
    assign bus.out_csraddr = w_head.csraddr;
    assign bus.out_areg    = w_head.areg;
    assign bus.out_is_env  = w_head.is_env;
    assign bus.out_is_mret = w_head.is_mret;
endmodule

// File: tb/tb_csr_eu_bcast.sv
// Bench for csr_eu_bcast: a 4-consumer, 2-deep instance and a 1-consumer,
// 3-deep instance for pointer wrap. The expected results come from a queue
// model that applies the operation rules directly.
module tb_csr_eu_bcast;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    // clock / reset
    always #5 clk = ~clk;

    csr_eu_bcast_if #(.XLEN(32), .TAG_W(4), .NUM_CONS(4)) bus ();
    csr_eu_bcast_if #(.XLEN(32), .TAG_W(4), .NUM_CONS(1)) bus2 ();

    csr_eu_bcast #(.XLEN(32), .TAG_W(4), .NUM_CONS(4), .DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    csr_eu_bcast #(.XLEN(32), .TAG_W(4), .NUM_CONS(1), .DEPTH(3)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  tag;
        logic        env;
        logic        mret;
        logic [11:0] addr;
        logic [31:0] csrdata;
        logic [31:0] src;
        logic [4:0]  areg;
    } op_t;

    typedef struct {
        logic [31:0] csrdata;
        logic [31:0] result;
        logic        wen;
        logic        ill;
        logic [3:0]  tag;
        logic [11:0] addr;
        logic [4:0]  areg;
        logic        env;
        logic        mret;
    } exp_t;

    // reference model: what the CSR instruction should produce
    function automatic exp_t model(op_t o);
        exp_t e;
        e.csrdata = o.csrdata;
        e.tag     = o.tag;
        e.addr    = o.addr;
        e.areg    = o.areg;
        e.env     = o.env;
        e.mret    = o.mret;
        e.result  = o.csrdata;
        e.wen     = 1'b0;
        e.ill     = 1'b0;
        if (o.op == 3'd0) begin
            e.result = o.src;
            e.wen    = 1'b1;
        end else if (o.op == 3'd1) begin
            e.result = o.csrdata | o.src;
            e.wen    = (o.areg != 0);
        end else if (o.op == 3'd2) begin
            e.result = o.csrdata & ~o.src;
            e.wen    = (o.areg != 0);
        end else if (o.op != 3'd3) begin
            e.ill    = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [88:0] pack_e(exp_t e);
        return {e.csrdata, e.result, e.wen, e.ill, e.tag, e.addr, e.areg, e.env, e.mret};
    endfunction

    function automatic logic [88:0] pack_dut();
        return {bus.out_csrdata, bus.out_result, bus.out_wen, bus.out_illegal, bus.out_tag,
                bus.out_csraddr, bus.out_areg, bus.out_is_env, bus.out_is_mret};
    endfunction

    function automatic logic [88:0] pack_dut2();
        return {bus2.out_csrdata, bus2.out_result, bus2.out_wen, bus2.out_illegal, bus2.out_tag,
                bus2.out_csraddr, bus2.out_areg, bus2.out_is_env, bus2.out_is_mret};
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.op      = 3'($urandom_range(0, 7));
        o.tag     = 4'($urandom);
        o.env     = 1'($urandom);
        o.mret    = 1'($urandom);
        o.addr    = 12'($urandom);
        o.csrdata = $urandom;
        o.src     = $urandom;
        o.areg    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        return o;
    endfunction

    function automatic op_t mk_op(logic [2:0] op, logic [3:0] tag, logic [31:0] csrdata,
                                  logic [31:0] src, logic [4:0] areg);
        op_t o;
        o.op = op; o.tag = tag; o.env = 1'b0; o.mret = 1'b0; o.addr = 12'h300;
        o.csrdata = csrdata; o.src = src; o.areg = areg;
        return o;
    endfunction

    // drivers
    task automatic drive(op_t o);
        bus.in_op = o.op; bus.in_tag = o.tag; bus.in_is_env = o.env; bus.in_is_mret = o.mret;
        bus.in_csraddr = o.addr; bus.in_csrdata = o.csrdata; bus.in_src = o.src; bus.in_areg = o.areg;
    endtask

    task automatic drive2(op_t o);
        bus2.in_op = o.op; bus2.in_tag = o.tag; bus2.in_is_env = o.env; bus2.in_is_mret = o.mret;
        bus2.in_csraddr = o.addr; bus2.in_csrdata = o.csrdata; bus2.in_src = o.src; bus2.in_areg = o.areg;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(mk_op(3'd0, 4'd7, 32'h1234_5678, 32'hCAFE_0000, 5'd1));
        drive2(mk_op(3'd0, 4'd7, 32'h1234_5678, 32'hCAFE_0000, 5'd1));
        bus.in_valid = 1'b1; bus.out_ready = 4'hF;
        bus2.in_valid = 1'b1; bus2.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.in_valid = 1'b0; bus2.in_valid = 1'b0; bus.out_ready = 4'h0;
        total++;
        if (bus.out_valid !== 4'h0) begin bad++; $display("FAIL reset_valid got=%h exp=0", bus.out_valid); end
        total++;
        if (bus.out_result !== 32'h0 || bus.out_csrdata !== 32'h0 || bus.out_tag !== 4'h0) begin
            bad++; $display("FAIL reset_data got=%h/%h/%h exp=0", bus.out_result, bus.out_csrdata, bus.out_tag);
        end
        total++;
        if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        total++;
        if (bus2.out_valid !== 1'b0 || bus2.in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_dut2 got valid=%b ready=%b exp 0/1", bus2.out_valid, bus2.in_ready);
        end
        step();
        total++;
        if (bus.out_valid !== 4'h0) begin bad++; $display("FAIL reset_no_accept got=%h exp=0", bus.out_valid); end
    endtask

    task automatic test_csrrs();
        drive(mk_op(3'd1, 4'd5, 32'h0000_00F0, 32'h0000_000F, 5'd3));
        bus.in_valid = 1'b1; bus.out_ready = 4'hF;
        total++;
        if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rs_in_ready got=%b exp=1", bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        total++;
        if (bus.out_valid !== 4'hF) begin bad++; $display("FAIL rs_valid got=%h exp=f", bus.out_valid); end
        total++;
        if (bus.out_result !== 32'hFF || bus.out_wen !== 1'b1 || bus.out_tag !== 4'd5) begin
            bad++; $display("FAIL rs_data got=%h wen=%b tag=%h exp=ff 1 5", bus.out_result, bus.out_wen, bus.out_tag);
        end
        step();
        total++;
        if (bus.out_valid !== 4'h0) begin bad++; $display("FAIL rs_retire got=%h exp=0", bus.out_valid); end
    endtask

    task automatic test_ops();
        op_t         ops [3];
        logic [31:0] er  [3];
        logic        ew  [3];
        logic        ei  [3];
        ops[0] = mk_op(3'd2, 4'd1, 32'hFFFF_FFFF, 32'h1, 5'd0);
        er[0] = 32'hFFFF_FFFE; ew[0] = 1'b0; ei[0] = 1'b0;
        ops[1] = mk_op(3'd0, 4'd2, 32'h0000_1234, 32'h0000_ABCD, 5'd0);
        er[1] = 32'h0000_ABCD; ew[1] = 1'b1; ei[1] = 1'b0;
        ops[2] = mk_op(3'd7, 4'd3, 32'hDEAD_BEEF, 32'h5555_5555, 5'd9);
        er[2] = 32'hDEAD_BEEF; ew[2] = 1'b0; ei[2] = 1'b1;
        bus.out_ready = 4'hF;
        for (int i = 0; i < 3; i++) begin
            drive(ops[i]);
            bus.in_valid = 1'b1;
            step();
            bus.in_valid = 1'b0;
            total++;
            if (bus.out_valid !== 4'hF || bus.out_result !== er[i] || bus.out_wen !== ew[i] ||
                bus.out_illegal !== ei[i] || bus.out_csrdata !== ops[i].csrdata) begin
                bad++;
                $display("FAIL ops_%0d got v=%h r=%h w=%b i=%b exp v=f r=%h w=%b i=%b",
                         i, bus.out_valid, bus.out_result, bus.out_wen, bus.out_illegal, er[i], ew[i], ei[i]);
            end
            step();
        end
    endtask

    task automatic test_stagger();
        logic [3:0] rdy [4];
        logic [3:0] expv [4];
        exp_t e;
        rdy[0] = 4'b0001; rdy[1] = 4'b0101; rdy[2] = 4'b0111; rdy[3] = 4'b1111;
        expv[0] = 4'b1111; expv[1] = 4'b1110; expv[2] = 4'b1010; expv[3] = 4'b1000;
        e = model(mk_op(3'd1, 4'd9, 32'h0F0F_0000, 32'h0000_F0F0, 5'd4));
        drive(mk_op(3'd1, 4'd9, 32'h0F0F_0000, 32'h0000_F0F0, 5'd4));
        bus.in_valid = 1'b1; bus.out_ready = 4'h0;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.out_ready = rdy[i];
            total++;
            if (bus.out_valid !== expv[i] || pack_dut() !== pack_e(e)) begin
                bad++; $display("FAIL stagger_%0d got v=%h d=%h exp v=%h d=%h", i, bus.out_valid, pack_dut(), expv[i], pack_e(e));
            end
            step();
        end
        bus.out_ready = 4'h0;
        total++;
        if (bus.out_valid !== 4'h0) begin bad++; $display("FAIL stagger_end got=%h exp=0", bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 4'b0111;
        drive(mk_op(3'd3, 4'd1, 32'hA, 32'h0, 5'd0));
        bus.in_valid = 1'b1;
        step();
        drive(mk_op(3'd3, 4'd2, 32'hB, 32'h0, 5'd0));
        total++;
        if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_second got=%b exp=1", bus.in_ready); end
        step();
        drive(mk_op(3'd3, 4'd3, 32'hC, 32'h0, 5'd0));
        total++;
        if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_full got=%b exp=0", bus.in_ready); end
        step();
        total++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 4'b1000 || bus.out_tag !== 4'd1) begin
            bad++; $display("FAIL bp_hold got r=%b v=%h t=%h exp 0 8 1", bus.in_ready, bus.out_valid, bus.out_tag);
        end
        bus.out_ready = 4'hF;
        step();
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 4'hF || bus.out_tag !== 4'd2) begin
            bad++; $display("FAIL bp_release got r=%b v=%h t=%h exp 1 f 2", bus.in_ready, bus.out_valid, bus.out_tag);
        end
        bus.out_ready = 4'h0;
        step();
        bus.in_valid = 1'b0;
        total++;
        if (bus.in_ready !== 1'b0 || bus.out_tag !== 4'd2) begin
            bad++; $display("FAIL bp_third got r=%b t=%h exp 0 2", bus.in_ready, bus.out_tag);
        end
        bus.out_ready = 4'hF;
        step();
        total++;
        if (bus.out_valid !== 4'hF || bus.out_tag !== 4'd3 || bus.out_csrdata !== 32'hC) begin
            bad++; $display("FAIL bp_drain got v=%h t=%h d=%h exp f 3 c", bus.out_valid, bus.out_tag, bus.out_csrdata);
        end
        step();
        total++;
        if (bus.out_valid !== 4'h0 || bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL bp_empty got v=%h r=%b exp 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_random();
        exp_t       exp_q [$];
        logic [3:0] mdone;
        logic [3:0] expv;
        logic [3:0] fired;
        logic       expr;
        op_t        o;
        mdone = 4'h0;
        for (int cyc = 0; cyc < 240; cyc++) begin
            o = rand_op();
            drive(o);
            if (cyc >= 200) begin
                bus.in_valid = 1'b0; bus.out_ready = 4'hF;
            end else begin
                bus.in_valid = 1'($urandom_range(0, 1));
                for (int i = 0; i < 4; i++) bus.out_ready[i] = ($urandom_range(0, 3) != 0);
            end
            expr = (exp_q.size() < 2);
            expv = (exp_q.size() > 0) ? ~mdone : 4'h0;
            total++;
            if (bus.in_ready !== expr || bus.out_valid !== expv) begin
                bad++; $display("FAIL rand_hs cyc=%0d got r=%b v=%h exp r=%b v=%h", cyc, bus.in_ready, bus.out_valid, expr, expv);
            end
            if (exp_q.size() > 0) begin
                total++;
                if (pack_dut() !== pack_e(exp_q[0])) begin
                    bad++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", cyc, pack_dut(), pack_e(exp_q[0]));
                end
            end
            fired = expv & bus.out_ready;
            if (exp_q.size() > 0 && (mdone | fired) == 4'hF) begin
                void'(exp_q.pop_front());
                mdone = 4'h0;
            end else begin
                mdone = mdone | fired;
            end
            if (bus.in_valid && expr) exp_q.push_back(model(o));
            step();
        end
        total++;
        if (exp_q.size() != 0 || bus.out_valid !== 4'h0) begin
            bad++; $display("FAIL rand_drain got v=%h left=%0d exp 0 0", bus.out_valid, exp_q.size());
        end
        bus.out_ready = 4'h0;
    endtask

    task automatic test_wrap();
        exp_t exp_q [$];
        op_t  o;
        int   next_tag = 0;
        int   got = 0;
        int   cycles = 0;
        bus2.out_ready = 1'b1;
        while (got < 10 && cycles < 100) begin
            if (next_tag < 10) begin
                o = rand_op();
                o.tag = 4'(next_tag);
                drive2(o);
                bus2.in_valid = 1'b1;
            end else begin
                bus2.in_valid = 1'b0;
            end
            total++;
            if (bus2.out_valid !== (exp_q.size() > 0)) begin
                bad++; $display("FAIL wrap_valid cyc=%0d got=%b exp=%b", cycles, bus2.out_valid, exp_q.size() > 0);
            end
            if (exp_q.size() > 0) begin
                total++;
                if (pack_dut2() !== pack_e(exp_q[0]) || bus2.out_tag !== 4'(got)) begin
                    bad++; $display("FAIL wrap_data cyc=%0d got=%h exp=%h", cycles, pack_dut2(), pack_e(exp_q[0]));
                end
                void'(exp_q.pop_front());
                got++;
            end
            if (next_tag < 10) begin
                total++;
                if (bus2.in_ready !== 1'b1) begin
                    bad++; $display("FAIL wrap_in_ready cyc=%0d got=%b exp=1", cycles, bus2.in_ready);
                end else begin
                    exp_q.push_back(model(o));
                    next_tag++;
                end
            end
            step();
            cycles++;
        end
        bus2.in_valid = 1'b0;
        total++;
        if (got != 10) begin bad++; $display("FAIL wrap_count got=%0d exp=10", got); end
    endtask

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0; bus.out_ready = 4'h0;
        bus2.in_valid = 1'b0; bus2.out_ready = 1'b0;
        test_reset();
        test_csrrs();
        test_ops();
        test_stagger();
        test_back_to_back();
        test_random();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/csr_eu_bcast.md
Name: csr_eu_bcast

Overview:
Parametrised, clocked successor of the CSR execution unit. It computes the CSR write value for CSRRW/CSRRS/CSRRC/read-only operations and the write-enable. Results are buffered in a DEPTH-entry FIFO, and each head entry is broadcast to NUM_CONS consumers (issue, MD, branch, WB, ...) with an independent valid/ready handshake per consumer. An entry retires only after every consumer has taken it.

Parameters:
XLEN, 32, data width of CSR value and source operand
TAG_W, 4, width of instruction index tag
NUM_CONS, 4, number of broadcast consumers (1..8)
DEPTH, 2, result FIFO entries (>=1, need not be a power of 2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  issue presents an operation
in_ready  out  1  unit can accept (FIFO not full)
in_op  in  3  000 CSRRW, 001 CSRRS, 010 CSRRC, 011 CSR read-only, others illegal
in_tag  in  TAG_W  instruction index
in_is_env  in  1  ecall/ebreak marker, passed through
in_is_mret  in  1  mret marker, passed through
in_csraddr  in  12  CSR address
in_csrdata  in  XLEN  current CSR value (old value)
in_src  in  XLEN  rs1 value or zero-extended uimm
in_areg  in  5  rs1/uimm field, used for write suppression
out_valid  out  NUM_CONS  per-consumer valid for the head entry
out_ready  in  NUM_CONS  per-consumer ready
out_csrdata  out  XLEN  old CSR value (rd writeback/forward)
out_result  out  XLEN  new CSR value
out_wen  out  1  CSR write required
out_illegal  out  1  unsupported op
out_tag, out_csraddr, out_areg, out_is_env, out_is_mret  out  TAG_W/12/5/1/1  head-entry passthrough

Behaviour:
- Reset (rst=1 at posedge): count=0, rd/wr pointers=0, done mask=0. All out_valid=0. All data outputs read 0 (storage cleared). in_ready=1 from the first cycle after reset. Reset overrides any same-cycle handshake.
- Accept: in_valid & in_ready at a posedge writes one entry. in_ready = (count < DEPTH) and does not depend on same-cycle pops: a full FIFO never accepts, even if the head retires in that cycle.
- Compute, combinational at accept time, stored in the entry:
  - CSRRW: result=src, wen=1.
  - CSRRS: result=csrdata|src, wen=(areg!=0).
  - CSRRC: result=csrdata&~src, wen=(areg!=0).
  - Read-only: result=csrdata, wen=0.
  - Illegal op: result=csrdata, wen=0, illegal=1.
  - csrdata, tag, csraddr, areg, is_env and is_mret are stored unchanged.
- Latency: an entry accepted at edge N into an empty FIFO drives out_valid from cycle N+1. There is no combinational in-to-out path.
- Broadcast: all data outputs always show the head entry. out_valid[i] = (count>0) & ~done[i].
- A consumer handshake (out_valid[i] & out_ready[i]) sets done[i] at the edge.
- Retire: when (done | fired) == all ones, pop the head, clear done to 0, and advance rd_ptr. The next entry is presented in the following cycle with all out_valid high.
- Consumers may complete in any order and any cycle. One consumer holding ready low stalls the retire. Data outputs stay stable while any out_valid bit is high.
- Simultaneous push and pop with count<DEPTH: count is unchanged and both pointers advance.
- Pointers wrap from DEPTH-1 to 0. Count range is 0..DEPTH.
- A ready asserted with its out_valid low has no effect.

Test Plan:
1. Reset with in_valid=1 -> no accept; afterwards out_valid=0, out_result=0, in_ready=1.
2. CSRRS: csrdata=0x0000_00F0, src=0x0F, areg=3; all readys high -> out_valid=4'hF in the next cycle, out_result=0xFF, out_wen=1. Entry retires after 1 cycle and out_valid returns to 0.
3. CSRRC: csrdata=0xFFFF_FFFF, src=0x1, areg=0 -> result=0xFFFF_FFFE, wen=0. CSRRW with areg=0 -> wen=1. Op 3'b111 -> illegal=1, result=csrdata.
4. Staggered ready: consumers 0, 2, 1, 3 accept on successive cycles. out_valid walks 1111 -> 1110 -> 1010 -> 1000 -> 0000. Pop occurs only on the 4th handshake, and data stays stable throughout.
5. Backpressure with DEPTH=2: consumer 3 holds ready low while 3 ops are offered -> in_ready drops after 2 accepts. Releasing ready retires head 1, and the 3rd op is accepted the cycle after.
6. Wrap with DEPTH=3, NUM_CONS=1: stream 10 ops with continuous ready -> outputs appear in order with tags 0..9 and no loss across pointer wrap.
